// File: rtl/nv_fetch_seq_if.sv
// nv_fetch_seq_if: command, tile_bram NV read and pair-stream signals of the NV fetch sequencer
interface nv_fetch_seq_if #(
  parameter int MAN_WIDTH = 256,
  parameter int IDX_WIDTH = 7,
  parameter int DIM_WIDTH = 8
);
  logic                        i_cmd_valid;
  logic                        o_cmd_ready;
  logic [IDX_WIDTH-1:0]        i_cmd_left_base;
  logic [IDX_WIDTH-1:0]        i_cmd_right_base;
  logic [DIM_WIDTH-1:0]        i_cmd_dim_b;
  logic [DIM_WIDTH-1:0]        i_cmd_dim_c;
  logic [DIM_WIDTH-1:0]        i_cmd_dim_v;
  logic [IDX_WIDTH-1:0]        o_nv_left_rd_idx;
  logic [IDX_WIDTH-1:0]        o_nv_right_rd_idx;
  logic [31:0]                 i_nv_left_exp;
  logic [31:0]                 i_nv_right_exp;
  logic [0:3][MAN_WIDTH-1:0]   i_nv_left_man;
  logic [0:3][MAN_WIDTH-1:0]   i_nv_right_man;
  logic                        o_pair_valid;
  logic                        i_pair_ready;
  logic [31:0]                 o_left_exp;
  logic [31:0]                 o_right_exp;
  logic [0:3][MAN_WIDTH-1:0]   o_left_man;
  logic [0:3][MAN_WIDTH-1:0]   o_right_man;
  logic                        o_pair_last_v;
  logic                        o_pair_last;
  logic                        o_busy;
  logic                        o_done;
  modport slave (
    input  i_cmd_valid, i_cmd_left_base, i_cmd_right_base, i_cmd_dim_b, i_cmd_dim_c, i_cmd_dim_v,
    input  i_nv_left_exp, i_nv_right_exp, i_nv_left_man, i_nv_right_man, i_pair_ready,
    output o_cmd_ready, o_nv_left_rd_idx, o_nv_right_rd_idx, o_pair_valid,
    output o_left_exp, o_right_exp, o_left_man, o_right_man,
    output o_pair_last_v, o_pair_last, o_busy, o_done
  );
  modport master (
    output i_cmd_valid, i_cmd_left_base, i_cmd_right_base, i_cmd_dim_b, i_cmd_dim_c, i_cmd_dim_v,
    output i_nv_left_exp, i_nv_right_exp, i_nv_left_man, i_nv_right_man, i_pair_ready,
    input  o_cmd_ready, o_nv_left_rd_idx, o_nv_right_rd_idx, o_pair_valid,
    input  o_left_exp, o_right_exp, o_left_man, o_right_man,
    input  o_pair_last_v, o_pair_last, o_busy, o_done
  );
endinterface

// File: rtl/nv_fetch_seq.sv
// nv_fetch_seq: walks left/right NV indices in b->c->v order and registers each tile_bram pair into a valid/ready stream
module nv_fetch_seq #(
  parameter int IDX_WIDTH = 7,
  parameter int DIM_WIDTH = 8
) (
  input logic          i_clk,
  input logic          i_reset,
  nv_fetch_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nxt;
  logic [DIM_WIDTH-1:0] dim_b, dim_c, dim_v, b, c, v;
  logic [IDX_WIDTH-1:0] left_row, right_row, right_base, step;
  logic issue, last_v, last_c, last_b, final_pair, zero_dim, cmd_fire;
  assign step       = IDX_WIDTH'(dim_v);
  assign last_v     = v == dim_v - DIM_WIDTH'(1);
  assign last_c     = c == dim_c - DIM_WIDTH'(1);
  assign last_b     = b == dim_b - DIM_WIDTH'(1);
  assign final_pair = last_v && last_c && last_b;
  assign zero_dim   = bus.i_cmd_dim_b == '0 || bus.i_cmd_dim_c == '0 || bus.i_cmd_dim_v == '0;
  assign cmd_fire   = state == IDLE && bus.i_cmd_valid;
  assign issue      = state == RUN && (!bus.o_pair_valid || bus.i_pair_ready);
  assign bus.o_cmd_ready       = state == IDLE;
  assign bus.o_busy            = state != IDLE;
  assign bus.o_done            = state == DONE;
  assign bus.o_nv_left_rd_idx  = left_row + IDX_WIDTH'(v);
  assign bus.o_nv_right_rd_idx = right_row + IDX_WIDTH'(v);
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  state_nxt = bus.i_cmd_valid ? (zero_dim ? DONE : RUN) : IDLE;
      RUN:   state_nxt = issue && final_pair ? DRAIN : RUN;
      DRAIN: state_nxt = bus.o_pair_valid && bus.i_pair_ready ? DONE : DRAIN;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge i_clk)
    state <= i_reset ? IDLE : state_nxt;
  // Row offsets step by V per b or c advance so the index needs only an adder.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      {dim_b, dim_c, dim_v, b, c, v} <= '0;
      {left_row, right_row, right_base} <= '0;
    end else if (cmd_fire) begin
      dim_b      <= bus.i_cmd_dim_b;
      dim_c      <= bus.i_cmd_dim_c;
      dim_v      <= bus.i_cmd_dim_v;
      {b, c, v}  <= '0;
      left_row   <= bus.i_cmd_left_base;
      right_row  <= bus.i_cmd_right_base;
      right_base <= bus.i_cmd_right_base;
    end else if (issue) begin
      v <= last_v ? '0 : v + DIM_WIDTH'(1);
      if (last_v) begin
        c         <= last_c ? '0 : c + DIM_WIDTH'(1);
        right_row <= last_c ? right_base : right_row + step;
        if (last_c) begin
          b        <= b + DIM_WIDTH'(1);
          left_row <= left_row + step;
        end
      end
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      bus.o_pair_valid  <= 1'b0;
      bus.o_pair_last_v <= 1'b0;
      bus.o_pair_last   <= 1'b0;
      bus.o_left_exp    <= '0;
      bus.o_right_exp   <= '0;
      bus.o_left_man    <= '0;
      bus.o_right_man   <= '0;
    end else if (issue) begin
      bus.o_pair_valid  <= 1'b1;
      bus.o_pair_last_v <= last_v;
      bus.o_pair_last   <= final_pair;
      bus.o_left_exp    <= bus.i_nv_left_exp;
      bus.o_right_exp   <= bus.i_nv_right_exp;
      bus.o_left_man    <= bus.i_nv_left_man;
      bus.o_right_man   <= bus.i_nv_right_man;
    end else if (bus.i_pair_ready) begin
      bus.o_pair_valid  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_nv_fetch_seq.sv
// tb_nv_fetch_seq: randomized check of nv_fetch_seq against a loop-nest model of the pair sequence
module tb_nv_fetch_seq;
  localparam int IW = 7;
  localparam int DW = 8;
  localparam int MW = 256;
  typedef logic [0:3][MW-1:0] man_t;
  typedef struct {int li; int ri; bit lv; bit last;} pair_t;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  nv_fetch_seq_if #(.MAN_WIDTH(MW), .IDX_WIDTH(IW), .DIM_WIDTH(DW)) bus ();
  nv_fetch_seq #(.IDX_WIDTH(IW), .DIM_WIDTH(DW)) dut (.i_clk(clk), .i_reset(rst), .bus(bus));
  logic [31:0] lexp [128];
  logic [31:0] rexp [128];
  man_t lman [128];
  man_t rman [128];
  assign bus.i_nv_left_exp  = lexp[bus.o_nv_left_rd_idx];
  assign bus.i_nv_right_exp = rexp[bus.o_nv_right_rd_idx];
  assign bus.i_nv_left_man  = lman[bus.o_nv_left_rd_idx];
  assign bus.i_nv_right_man = rman[bus.o_nv_right_rd_idx];
  pair_t q[$];
  int errors = 0;
  int checks = 0;
  task automatic check(string tag, logic [MW-1:0] got, logic [MW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run_cmd(int lb, int rb, int bb, int cc, int vv, bit bp, bit poke, int abort);
    int n, k, popped, done_k, first_k;
    bit stalled, aborting;
    logic [31:0] sle, sre;
    man_t slm, srm;
    pair_t e;
    q.delete();
    for (int i = 0; i < bb; i++)
      for (int j = 0; j < cc; j++)
        for (int x = 0; x < vv; x++)
          q.push_back('{li: (lb + i * vv + x) % 128, ri: (rb + j * vv + x) % 128,
                        lv: x == vv - 1, last: i == bb - 1 && j == cc - 1 && x == vv - 1});
    n = q.size();
    k = 0;
    while (!bus.o_cmd_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("cmd_ready_wait", bus.o_cmd_ready, 1);
    bus.i_cmd_valid      = 1;
    bus.i_cmd_left_base  = IW'(lb);
    bus.i_cmd_right_base = IW'(rb);
    bus.i_cmd_dim_b      = DW'(bb);
    bus.i_cmd_dim_c      = DW'(cc);
    bus.i_cmd_dim_v      = DW'(vv);
    @(negedge clk);
    bus.i_cmd_valid = 0;
    done_k = 0;
    first_k = 0;
    popped = 0;
    stalled = 0;
    aborting = 0;
    for (k = 1; k <= 4 * n + 20; k++) begin
      if (k > 1) @(negedge clk);
      if (aborting) begin
        check("rst_valid", bus.o_pair_valid, 0);
        check("rst_busy", bus.o_busy, 0);
        check("rst_cmd_ready", bus.o_cmd_ready, 1);
        check("rst_done", bus.o_done, 0);
        rst = 0;
        q.delete();
        return;
      end
      if (poke && k == 1) begin
        check("busy_cmd_ready", bus.o_cmd_ready, 0);
        bus.i_cmd_valid = 1;
        bus.i_cmd_dim_b = 1;
        bus.i_cmd_dim_c = 1;
        bus.i_cmd_dim_v = 1;
      end else if (poke && k == 2) bus.i_cmd_valid = 0;
      if (done_k > 0) begin
        check("cmd_ready_after", bus.o_cmd_ready, 1);
        check("done_one_cycle", bus.o_done, 0);
        break;
      end
      if (k == 1) begin
        check("busy", bus.o_busy, 1);
        if (n > 0) begin
          check("rd_idx_l", bus.o_nv_left_rd_idx, lb % 128);
          check("rd_idx_r", bus.o_nv_right_rd_idx, rb % 128);
        end
      end
      if (stalled) begin
        check("hold_valid", bus.o_pair_valid, 1);
        check("hold_lexp", bus.o_left_exp, sle);
        check("hold_rexp", bus.o_right_exp, sre);
        for (int g = 0; g < 4; g++) begin
          check("hold_lman", bus.o_left_man[g], slm[g]);
          check("hold_rman", bus.o_right_man[g], srm[g]);
        end
      end
      bus.i_pair_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = 0;
      if (bus.o_pair_valid) begin
        if (first_k == 0) first_k = k;
        if (bus.i_pair_ready) begin
          if (q.size() == 0) check("extra_pair", 1, 0);
          else begin
            e = q.pop_front();
            popped++;
            check("lexp", bus.o_left_exp, lexp[e.li]);
            check("rexp", bus.o_right_exp, rexp[e.ri]);
            for (int g = 0; g < 4; g++) begin
              check("lman", bus.o_left_man[g], lman[e.li][g]);
              check("rman", bus.o_right_man[g], rman[e.ri][g]);
            end
            check("last_v", bus.o_pair_last_v, e.lv);
            check("last", bus.o_pair_last, e.last);
            if (abort > 0 && popped == abort) begin
              rst = 1;
              aborting = 1;
            end
          end
        end else begin
          stalled = 1;
          sle = bus.o_left_exp;
          sre = bus.o_right_exp;
          slm = bus.o_left_man;
          srm = bus.o_right_man;
        end
      end
      if (bus.o_done) begin
        done_k = k;
        check("drained", q.size(), 0);
        if (!bp) begin
          check("first_lat", first_k, n > 0 ? 2 : 0);
          check("done_lat", k, n > 0 ? n + 2 : 1);
        end
      end
    end
    check("done_seen", done_k != 0, 1);
  endtask
  initial begin
    bus.i_cmd_valid = 0;
    bus.i_cmd_left_base = 0;
    bus.i_cmd_right_base = 0;
    bus.i_cmd_dim_b = 0;
    bus.i_cmd_dim_c = 0;
    bus.i_cmd_dim_v = 0;
    bus.i_pair_ready = 0;
    for (int i = 0; i < 128; i++) begin
      lexp[i] = $urandom;
      rexp[i] = $urandom;
      for (int g = 0; g < 4; g++)
        for (int w = 0; w < MW / 32; w++) begin
          lman[i][g][w*32 +: 32] = $urandom;
          rman[i][g][w*32 +: 32] = $urandom;
        end
    end
    repeat (3) @(negedge clk);
    check("rst_pair_valid", bus.o_pair_valid, 0);
    check("rst_last_v", bus.o_pair_last_v, 0);
    check("rst_last", bus.o_pair_last, 0);
    check("rst_busy0", bus.o_busy, 0);
    check("rst_done0", bus.o_done, 0);
    check("rst_cmd_ready0", bus.o_cmd_ready, 1);
    check("rst_lidx", bus.o_nv_left_rd_idx, 0);
    check("rst_ridx", bus.o_nv_right_rd_idx, 0);
    check("rst_lexp", bus.o_left_exp, 0);
    check("rst_rman", bus.o_right_man[3], 0);
    rst = 0;
    @(negedge clk);
    run_cmd(0, 0, 1, 1, 4, 0, 0, 0);
    run_cmd(10, 20, 2, 3, 2, 0, 1, 0);
    run_cmd(10, 20, 2, 3, 2, 1, 0, 0);
    run_cmd(126, 127, 1, 1, 4, 0, 0, 0);
    run_cmd(3, 4, 2, 2, 0, 0, 1, 0);
    run_cmd(5, 6, 0, 3, 2, 0, 0, 0);
    run_cmd(10, 20, 2, 3, 2, 0, 0, 3);
    run_cmd(40, 50, 2, 2, 3, 0, 0, 0);
    for (int t = 0; t < 8; t++)
      run_cmd($urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(1, 4),
              $urandom_range(1, 4), $urandom_range(1, 4), 1, t % 2 == 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/nv_fetch_seq.md
# nv_fetch_seq

Downstream NV fetch sequencer for the tile compute engine. It accepts one tile command: left/right NV base indices and B/C/V loop dimensions. It walks the Native Vector index space of `tile_bram` in b→c→v order, driving the combinational NV read indices and registering each left/right NV pair into a valid/ready stream. The dot-product engine consumes that stream. It sits between `tile_bram`'s NV read ports and the compute core, and it hides the zero-latency BRAM read behind a registered, back-pressurable output.

## Interface
- MAN_WIDTH, 256, mantissa group width (matches `tile_bram`)
- IDX_WIDTH, 7, NV index width (128 NVs per side)
- DIM_WIDTH, 8, width of each loop dimension field
- i_clk  in  1  clock
- i_reset  in  1  synchronous reset, active-high
- i_cmd_valid  in  1  command offered
- o_cmd_ready  out  1  command accepted when high with i_cmd_valid
- i_cmd_left_base  in  IDX_WIDTH  first left NV index
- i_cmd_right_base  in  IDX_WIDTH  first right NV index
- i_cmd_dim_b / i_cmd_dim_c / i_cmd_dim_v  in  DIM_WIDTH each  left rows, right columns, NVs per dot product
- o_nv_left_rd_idx / o_nv_right_rd_idx  out  IDX_WIDTH  to `tile_bram` NV read index
- i_nv_left_exp / i_nv_right_exp  in  32  packed exponents from `tile_bram`
- i_nv_left_man / i_nv_right_man  in  MAN_WIDTH x [0:3]  mantissa groups from `tile_bram`
- o_pair_valid  out  1  output pair valid
- i_pair_ready  in  1  consumer ready
- o_left_exp / o_right_exp  out  32  registered exponents
- o_left_man / o_right_man  out  MAN_WIDTH x [0:3]  registered mantissas
- o_pair_last_v  out  1  pair is the last of a dot product (v == V-1)
- o_pair_last  out  1  final pair of the command
- o_busy  out  1  command in progress
- o_done  out  1  one-cycle pulse on command completion

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- **IDLE**
  - o_cmd_ready = 1.
  - On handshake, latch bases and dims, clear b/c/v counters, and go to RUN.
  - If any dim is 0, go to DONE instead; no pairs are emitted.
- **Index generation**
  - left_idx = left_base + b·V + v.
  - right_idx = right_base + c·V + v.
  - Both are mod 2^IDX_WIDTH, so they wrap 127→0.
  - Implement with running row offsets (add V per b or c step); no multipliers.
- **Loop order**
  - v fastest, then c, then b.
  - After v = V-1: v←0, c++.
  - After c = C-1: c←0, b++.
  - Total pairs = B·C·V.
- **Issue condition**
  - Issue when in RUN and (!o_pair_valid || i_pair_ready).
  - On issue: capture `tile_bram` outputs for the current indices into the output register, set o_pair_valid, set o_pair_last_v and o_pair_last, and advance the counters.
  - o_nv_*_rd_idx always shows the current (next-to-issue) indices.
- After issuing the final pair, go to DRAIN.
- **DRAIN**: hold until the final pair handshakes, then go to DONE.
- **DONE**: o_done = 1 for one cycle, then IDLE.
- o_busy = 1 in RUN, DRAIN and DONE.
- **Stall**: counters, indices and all output registers hold while o_pair_valid && !i_pair_ready.
- Data is sampled at issue time. `tile_bram` writes to NVs not yet issued are visible; writes to already-registered pairs are not.
- A command offered while not IDLE is ignored (o_cmd_ready = 0).

## Timing
- **Reset values**: state IDLE; o_cmd_ready 1; o_pair_valid, o_pair_last_v, o_pair_last, o_busy, o_done all 0; o_nv_*_rd_idx 0; output data registers 0.
- **Reset mid-operation**
  - Abort immediately; next cycle is IDLE.
  - No o_done pulse.
  - The pending pair is dropped (o_pair_valid 0).
- **Latency, full run**
  - Command handshake at cycle T.
  - First o_pair_valid at T+2.
  - With i_pair_ready held high, one pair per cycle.
  - Last pair at T+1+B·C·V.
  - o_done at T+2+B·C·V.
  - o_cmd_ready at T+3+B·C·V.
- **Latency, zero-dim command**: o_done at T+1, o_cmd_ready again at T+2.
- **Back-pressure**: o_pair_valid never deasserts without a handshake; payload is stable while stalled.
- **Simultaneous events**: handshake and issue in the same cycle replace the register with no bubble.

## Test plan
- **Simple run**: B=1, C=1, V=4, bases 0/0, ready high → 4 pairs with left/right idx 0,1,2,3. Data matches preloaded NVs. last_v and last set on pair 4; o_done at T+6.
- **Multi-loop order**: B=2, C=3, V=2, left_base 10, right_base 20.
  - 12 pairs; left idx sequence 10,11 ×3, then 12,13 ×3.
  - Right idx sequence 20,21,22,23,24,25, repeated twice.
  - last_v on every 2nd pair.
- **Back-pressure**: same command with i_pair_ready randomly toggled → identical pair sequence, payload stable across stalls, no drops or duplicates.
- **Wrap**: left_base 126, right_base 127, B=C=1, V=4 → left idx 126,127,0,1; right idx 127,0,1,2.
- **Zero dim**: V=0 → no o_pair_valid, o_done at T+1, o_cmd_ready at T+2. A command offered during busy is not accepted.
- **Reset mid-run**: i_reset after 3 pairs of a 12-pair run → next cycle o_pair_valid 0, o_busy 0, o_cmd_ready 1, no o_done. A new command then runs correctly from its base.
